// File: rtl/synth_pkg.sv
// Types and constants shared by the synth blocks (sequencer, tone generator).
// No logic; nothing here adds latency or flow control.
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    PLAY = 2'd2
  } tone_state_t;

  localparam int unsigned CLK_HZ         = 50_000_000;
  localparam logic [23:0] DEF_GAP_CYCLES = 24'd250000;
  localparam logic [15:0] DEF_MIN_PERIOD = 16'd32;

endpackage

// File: rtl/pwm_level.sv
// Free-running 4-bit PWM counter and level compare; gate is combinational from the counter flop.
// Level 15 gives a constant-high gate, level 0 a constant-low gate; no flow control.
module pwm_level (
  input  logic       clk50,
  input  logic       reset,
  input  logic [3:0] volume,
  output logic       gate
);

  logic [3:0] pwm_cnt_q;
  logic [3:0] pwm_cnt_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 4'd1;
  end

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      pwm_cnt_q <= 4'd0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  assign gate = (volume == 4'd15) || (pwm_cnt_q < volume);

endmodule

// File: rtl/tone_gen.sv
// Square-wave tone generator: note word -> speaker pin with articulation gap and PWM volume.
// Period change to FSM/strobe is 2 edges, to audio_out/note_active 3 edges; no flow control.
module tone_gen
  import synth_pkg::*;
#(
  parameter logic [23:0] GAP_CYCLES = DEF_GAP_CYCLES,
  parameter logic [15:0] MIN_PERIOD = DEF_MIN_PERIOD
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic [15:0] period,
  input  logic        enable,
  input  logic [3:0]  volume,
  output logic        audio_out,
  output logic        note_active,
  output logic        note_strobe
);

  tone_state_t state_q, state_d;
  logic [15:0] p_s_q, p_s_d;
  logic [15:0] active_period_q, active_period_d;
  logic [15:0] half_cnt_q, half_cnt_d;
  logic        phase_q, phase_d;
  logic [23:0] gap_cnt_q, gap_cnt_d;
  logic        audio_out_q, audio_out_d;
  logic        note_active_q, note_active_d;
  logic        note_strobe_q, note_strobe_d;

  logic        pwm_gate;
  logic        note_valid;
  logic        note_change;

  pwm_level u_pwm_level (
    .clk50  (clk50),
    .reset  (reset),
    .volume (volume),
    .gate   (pwm_gate)
  );

  always_comb begin
    p_s_d           = period;
    note_valid      = (p_s_q >= MIN_PERIOD);
    note_change     = (p_s_q != active_period_q);
    state_d         = state_q;
    active_period_d = active_period_q;
    half_cnt_d      = half_cnt_q;
    phase_d         = phase_q;
    gap_cnt_d       = gap_cnt_q;
    note_strobe_d   = 1'b0;
    audio_out_d     = (state_q == PLAY) && phase_q && pwm_gate;
    note_active_d   = (state_q == PLAY);

    // Silence requests outrank every note event.
    if (!enable || !note_valid) begin
      state_d    = IDLE;
      half_cnt_d = 16'd0;
      phase_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          active_period_d = p_s_q;
          half_cnt_d      = 16'd0;
          phase_d         = 1'b1;
          note_strobe_d   = 1'b1;
          state_d         = PLAY;
        end
        PLAY: begin
          if (note_change) begin
            active_period_d = p_s_q;
            gap_cnt_d       = 24'd0;
            note_strobe_d   = 1'b1;
            state_d         = GAP;
          end else if (half_cnt_q == active_period_q - 16'd1) begin
            half_cnt_d = 16'd0;
            phase_d    = ~phase_q;
          end else begin
            half_cnt_d = half_cnt_q + 16'd1;
          end
        end
        GAP: begin
          if (note_change) begin
            active_period_d = p_s_q;
            gap_cnt_d       = 24'd0;
            note_strobe_d   = 1'b1;
          end else if (gap_cnt_q == GAP_CYCLES - 24'd1) begin
            half_cnt_d = 16'd0;
            phase_d    = 1'b1;
            state_d    = PLAY;
          end else begin
            gap_cnt_d = gap_cnt_q + 24'd1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      p_s_q           <= 16'd0;
      active_period_q <= 16'd0;
      half_cnt_q      <= 16'd0;
      phase_q         <= 1'b0;
      gap_cnt_q       <= 24'd0;
      audio_out_q     <= 1'b0;
      note_active_q   <= 1'b0;
      note_strobe_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      p_s_q           <= p_s_d;
      active_period_q <= active_period_d;
      half_cnt_q      <= half_cnt_d;
      phase_q         <= phase_d;
      gap_cnt_q       <= gap_cnt_d;
      audio_out_q     <= audio_out_d;
      note_active_q   <= note_active_d;
      note_strobe_q   <= note_strobe_d;
    end
  end

  assign audio_out   = audio_out_q;
  assign note_active = note_active_q;
  assign note_strobe = note_strobe_q;

endmodule

// File: tb/tb_tone_gen.sv
// Bench for tone_gen: per-cycle expected outputs from a note/time model are queued and
// compared by an independent monitor after each rising edge.
module tb_tone_gen;

  localparam int GAP = 10;
  localparam int MINP = 32;
  localparam int M_IDLE = 0;
  localparam int M_GAP = 1;
  localparam int M_PLAY = 2;

  logic        clk50 = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] period = 16'd0;
  logic        enable = 1'b0;
  logic [3:0]  volume = 4'd0;
  logic        audio_out;
  logic        note_active;
  logic        note_strobe;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  // Model state: delayed note word, mode, current note, time in PLAY, time in GAP, edges since reset.
  int m_ps, m_mode, m_note, m_t, m_gap, m_cyc;

  tone_gen #(.GAP_CYCLES(24'd10), .MIN_PERIOD(16'd32)) dut (
    .clk50       (clk50),
    .reset       (reset),
    .period      (period),
    .enable      (enable),
    .volume      (volume),
    .audio_out   (audio_out),
    .note_active (note_active),
    .note_strobe (note_strobe)
  );

  always #10 clk50 = ~clk50;

  task automatic check(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  task automatic reset_model();
    m_ps = 0; m_mode = M_IDLE; m_note = 0; m_t = 0; m_gap = 0; m_cyc = 0;
  endtask

  task automatic tick(input int per, input logic en, input logic [3:0] vol, input logic rst_val);
    logic a, na, st;
    @(negedge clk50);
    period = per[15:0];
    enable = en;
    volume = vol;
    reset  = rst_val;
    if (!rst_val) begin
      exp_q.push_back(3'b000);
      return;
    end
    a  = (m_mode == M_PLAY) && (((m_t / m_note) % 2) == 0) && (vol == 4'd15 || (m_cyc % 16) < vol);
    na = (m_mode == M_PLAY);
    st = 1'b0;
    if (!en || m_ps < MINP) begin
      m_mode = M_IDLE;
    end else if (m_mode == M_IDLE) begin
      m_note = m_ps; m_mode = M_PLAY; m_t = 0; st = 1'b1;
    end else if (m_ps != m_note) begin
      m_note = m_ps; m_mode = M_GAP; m_gap = 0; st = 1'b1;
    end else if (m_mode == M_PLAY) begin
      m_t++;
    end else begin
      m_gap++;
      if (m_gap == GAP) begin
        m_mode = M_PLAY; m_t = 0;
      end
    end
    m_ps = per;
    m_cyc++;
    exp_q.push_back({a, na, st});
  endtask

  task automatic run(input int per, input logic en, input logic [3:0] vol, input int n);
    for (int i = 0; i < n; i++) tick(per, en, vol, 1'b1);
  endtask

  // Reset asserted between edges; outputs must drop without waiting for a clock.
  task automatic async_reset();
    @(negedge clk50);
    #2 reset = 1'b0;
    #1;
    check("async_audio_out", audio_out, 1'b0);
    check("async_note_active", note_active, 1'b0);
    check("async_note_strobe", note_strobe, 1'b0);
    reset_model();
    exp_q.push_back(3'b000);
  endtask

  initial begin : monitor
    logic [2:0] e;
    forever begin
      @(posedge clk50);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("audio_out", audio_out, e[2]);
        check("note_active", note_active, e[1]);
        check("note_strobe", note_strobe, e[0]);
      end
    end
  end

  initial begin : driver
    int pers[9];
    pers = '{0, 31, 32, 33, 40, 50, 64, 100, 200};
    reset_model();
    for (int i = 0; i < 3; i++) tick(100, 1'b1, 4'd15, 1'b0);
    run(100, 1'b1, 4'd15, 450);
    run(50, 1'b1, 4'd15, 300);
    run(100, 1'b1, 4'd4, 400);
    run(100, 1'b1, 4'd0, 100);
    run(31, 1'b1, 4'd15, 5);
    run(0, 1'b1, 4'd15, 5);
    run(100, 1'b1, 4'd15, 250);
    run(60, 1'b1, 4'd15, 5);
    run(60, 1'b0, 4'd15, 5);
    run(60, 1'b1, 4'd9, 300);
    for (int k = 8; k <= 13; k++) begin
      run(64, 1'b1, 4'd15, k);
      run(80, 1'b1, 4'd15, k);
    end
    run(32, 1'b1, 4'd15, 100);
    for (int j = 0; j < 4; j++) begin
      run(33, 1'b1, 4'd15, 30 + j);
      run(32, 1'b1, 4'd15, 30 + j);
    end
    run(100, 1'b1, 4'd15, 137);
    async_reset();
    for (int i = 0; i < 3; i++) tick(200, 1'b1, 4'd15, 1'b0);
    run(200, 1'b1, 4'd15, 500);
    for (int s = 0; s < 40; s++) begin
      int p;
      p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 300)) : pers[$urandom_range(0, 8)];
      run(p, ($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)), int'($urandom_range(1, 200)));
    end
    run(0, 1'b0, 4'd0, 4);
    repeat (2) @(posedge clk50);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_gen.md
# tone_gen

Square-wave tone generator that sits directly downstream of the scale/song sequencer. It consumes the 16-bit note word (half-period in `clk50` cycles, 0 = rest) and drives a 1-bit speaker pin. It inserts a short silent articulation gap on every note change and applies 4-bit PWM volume to the high phase of the tone.

## Interface
- `GAP_CYCLES`, 24'd250000: silent cycles inserted on each note change (5 ms at 50 MHz); must be ≥ 1.
- `MIN_PERIOD`, 16'd32: note words below this are treated as rest.
- `clk50` in 1: 50 MHz system clock.
- `reset` in 1: asynchronous, active-low reset.
- `period` in 16: note half-period in `clk50` cycles; 0 = rest.
- `enable` in 1: 0 forces silence.
- `volume` in 4: PWM level; 0 = mute, 15 = full (constant high).
- `audio_out` out 1: speaker drive, registered.
- `note_active` out 1: registered; high while in PLAY.
- `note_strobe` out 1: registered one-cycle pulse when a new note is accepted.

## Operation
- Input stage: `p_s` <= `period` every cycle. A note is valid when `p_s >= MIN_PERIOD`.
- Held state: `active_period` (16 b), `half_cnt` (16 b), `phase` (1 b), `gap_cnt` (24 b), free-running `pwm_cnt` (4 b).
- FSM states: IDLE, GAP, PLAY.
- IDLE
  - Condition: `enable` && valid.
  - Action: `active_period` <= `p_s`, `half_cnt` <= 0, `phase` <= 1, `note_strobe` pulse.
  - Next state: PLAY. There is no gap from IDLE.
- PLAY
  - `half_cnt` increments each cycle.
  - When `half_cnt == active_period-1`: `half_cnt` <= 0 and `phase` toggles.
  - When `p_s != active_period` and the new value is valid: `active_period` <= `p_s`, `gap_cnt` <= 0, `note_strobe` pulse, go to GAP.
- GAP
  - `gap_cnt` increments.
  - When `gap_cnt == GAP_CYCLES-1`: `half_cnt` <= 0, `phase` <= 1, go to PLAY.
  - When `p_s != active_period` and the new value is valid: latch it, restart `gap_cnt`, pulse `note_strobe`.
- Any state: `!enable` or invalid `p_s` → IDLE next edge, with `half_cnt` <= 0 and `phase` <= 0. This takes priority over all other transitions.
- Output registers:
  - `audio_out` <= (state==PLAY) && `phase` && (`volume`==15 || `pwm_cnt` < `volume`).
  - `note_active` <= (state==PLAY).
- Arithmetic: all counters are unsigned. `pwm_cnt` wraps 15→0. Period comparisons are full 16-bit; no truncation.

## Timing
- Reset values:
  - state = IDLE; `active_period`, `half_cnt`, `gap_cnt`, `pwm_cnt` = 0; `phase` = 0.
  - `audio_out`, `note_active`, `note_strobe` = 0.
- Reset is honoured mid-note: outputs drop on the asynchronous assertion edge with no cycle wait.
- Latency (input change at edge t):
  - `p_s` updates at edge t+1.
  - FSM transition and `note_strobe` rise at edge t+2.
  - `audio_out`/`note_active` reflect the new state at edge t+3.
- Tone period is exactly 2×`active_period` cycles. With `volume`=15, duty is exactly 50%.
- In GAP, `audio_out` is low for exactly `GAP_CYCLES` cycles, measured between `audio_out` register updates.
- Simultaneous events:
  - `!enable` beats a note change.
  - A note change on the same cycle as a half-period boundary beats the toggle.
  - A note change on the same cycle as GAP completion restarts the gap.
- Same-value re-presentation (sequencer repeats a note) produces no gap and no strobe.

## Structure
- Shared package `synth_pkg` holds:
  - state encoding `tone_state_t` {IDLE, GAP, PLAY};
  - `CLK_HZ` = 50_000_000;
  - default `GAP_CYCLES` and `MIN_PERIOD` constants, shared with the sequencer.
- One natural sub-module, `pwm_level`, contains `pwm_cnt` and the compare. It outputs a gate bit that is ANDed with `phase`. It is reusable by a future envelope stage.

## Test plan
- Start from IDLE with `period`=100, `volume`=15, `enable`=1 → `note_strobe` pulses once. `audio_out` then shows 100 high / 100 low, repeating. `note_active`=1.
- Change `period` 100→50 during PLAY with `GAP_CYCLES`=10 → one strobe, then exactly 10 low cycles, then a 50/50 square wave starting with the high phase.
- Set `period`=100, `volume`=4 → during each 100-cycle high phase, `audio_out` follows the 4-of-16 PWM pattern. The low phase stays all zero. `volume`=0 → constant 0 while `note_active` stays 1.
- Set `period`=31 (below `MIN_PERIOD`), then `period`=0 → IDLE within 2 edges, `audio_out`=0, no strobe. Re-present `period`=100 → immediate PLAY with no gap.
- Drop `enable` mid-gap, and separately present the same `period` value repeatedly → IDLE on the next FSM edge. Repeated values cause no strobe and no gap.
- Assert `reset` mid-PLAY at an arbitrary cycle → all outputs 0 asynchronously. After release with `period`=200, the first high phase lasts exactly 200 cycles.
